// File: rtl/hex_sched_pkg.sv
// -----------------------------------------------------------------------------
// hex_sched_pkg
// Shared types and constants for the HEX display scheduler.
//   state_t      : scheduler FSM states (IDLE, GRANT, SHOW, DONE)
//   SEG_BLANK    : active-high code for an unlit digit
//   SEG_H/E/L/O  : active-high letter codes used to build test messages
//   MAX_LEN      : longest message, in characters
//   clamp_len    : limits a requested length to MAX_LEN
//   pick_winner  : round-robin choice between the two requesters
//   grant_vec    : index -> one-hot grant/done vector
// -----------------------------------------------------------------------------
package hex_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHOW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_H     = 8'h76;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_L     = 8'h38;
  localparam logic [7:0] SEG_O     = 8'h3F;

  localparam logic [3:0] MAX_LEN = 4'd8;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  // A lone requester wins outright; on contention the one not served last wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    logic w;
    w = ~last;
    if (req == 2'b01) begin
      w = 1'b0;
    end else if (req == 2'b10) begin
      w = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [1:0] grant_vec(input logic who);
    return who ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// -----------------------------------------------------------------------------
// hex_tick_gen
// Scroll-rate divider. Counts enabled cycles and emits a one-cycle tick when
// the count reaches TICK_DIV-1, then wraps to 0. clear has priority and holds
// the count at 0, so the first tick lands exactly TICK_DIV enabled cycles
// after clear is released.
// Parameters:
//   TICK_DIV : cycles per tick (>= 2)
// Ports:
//   CLOCK_50 in  system clock
//   RST_N    in  asynchronous active-low reset
//   clear    in  force the count back to 0
//   enable   in  advance the count
//   tick     out one-cycle pulse, combinational from the count register
// -----------------------------------------------------------------------------
module hex_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = enable && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/hex_msg_sched.sv
// -----------------------------------------------------------------------------
// hex_msg_sched
// Shares a bank of 7-segment digits between two requesters. A round-robin
// arbiter grants one requester, its message (up to 8 characters) is latched
// and scrolled leftward across the digits one position per TICK_DIV cycles,
// and a one-cycle done pulse is returned to the served requester.
//
// Build option:
//   HEX_SCHED_ABORT_EN : when defined, the granted requester dropping its req
//                        during the scroll aborts it (no done pulse). When not
//                        defined, req is ignored once granted.
//
// Parameters:
//   TICK_DIV : CLOCK_50 cycles per scroll step (>= 2)
//   N_DIGITS : digits driven (the port list fixes this at 4)
// Ports:
//   CLOCK_50   in  system clock
//   RST_N      in  asynchronous active-low reset
//   req[1:0]   in  request level per requester
//   msg0/msg1  in  messages, char k at [8k+:8], active-high segments
//   len0/len1  in  message lengths, values above 8 clamp to 8
//   gnt[1:0]   out one-hot grant, held for the whole service
//   done[1:0]  out one-cycle completion pulse to the served requester
//   busy       out high whenever the scheduler is not idle
//   HEX0..HEX3 out active-low segments, HEX0 rightmost, 8'hFF blank
// -----------------------------------------------------------------------------
module hex_msg_sched
  import hex_sched_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int N_DIGITS = 4
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [1:0]  req,
  input  logic [63:0] msg0,
  input  logic [63:0] msg1,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        busy,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3
);

  localparam logic [7:0] HEX_OFF = ~SEG_BLANK;

  state_t      state_reg;
  state_t      state_next;
  logic        winner_reg;
  logic        winner_next;
  logic        last_reg;
  logic        last_next;
  logic [63:0] msg_reg;
  logic [63:0] msg_next;
  logic [3:0]  len_reg;
  logic [3:0]  len_next;
  logic [3:0]  p_reg;
  logic [3:0]  p_next;
  logic [1:0]  gnt_reg;
  logic [1:0]  gnt_next;
  logic [1:0]  done_reg;
  logic [1:0]  done_next;

  logic [N_DIGITS-1:0][7:0] hex_reg;
  logic [N_DIGITS-1:0][7:0] hex_next;

  logic        tick;
  logic        abort;
  logic [3:0]  grant_len;
  logic [3:0]  last_pos;

  // Position at which every character has scrolled off the left edge.
  assign last_pos = len_reg + 4'(N_DIGITS - 1);

  hex_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .clear    (state_reg != SHOW),
    .enable   (state_reg == SHOW),
    .tick     (tick)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath-next logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    last_next   = last_reg;
    msg_next    = msg_reg;
    len_next    = len_reg;
    p_next      = p_reg;
    gnt_next    = gnt_reg;
    done_next   = 2'b00;
    abort       = 1'b0;
    grant_len   = clamp_len(winner_reg ? len1 : len0);

    unique case (state_reg)
      IDLE: begin
        p_next   = '0;
        gnt_next = 2'b00;
        // Winner is fixed on the way into GRANT so that a req change during
        // the GRANT cycle cannot redirect the latch.
        if (|req) begin
          winner_next = pick_winner(req, last_reg);
          state_next  = GRANT;
        end
      end

      GRANT: begin
        msg_next   = winner_reg ? msg1 : msg0;
        len_next   = grant_len;
        gnt_next   = grant_vec(winner_reg);
        p_next     = '0;
        state_next = (grant_len == 4'd0) ? DONE : SHOW;
      end

      SHOW: begin
`ifdef HEX_SCHED_ABORT_EN
        abort = ~req[winner_reg];
`endif
        // Abort is checked first so it beats a coincident tick.
        if (abort) begin
          state_next = IDLE;
          gnt_next   = 2'b00;
          last_next  = winner_reg;
          p_next     = '0;
        end else if (tick) begin
          if (p_reg == last_pos) begin
            state_next = DONE;
          end else begin
            p_next = p_reg + 4'd1;
          end
        end
      end

      DONE: begin
        done_next  = grant_vec(winner_reg);
        gnt_next   = 2'b00;
        last_next  = winner_reg;
        p_next     = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit rendering: digit d shows character p-d while it is inside the
  // message, otherwise blank. The visible index is below len <= 8, so its
  // low three bits address the latched message.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] char_idx;
      logic       char_vis;

      assign char_idx = p_reg - 4'(gi);
      assign char_vis = (state_reg == SHOW) && !abort &&
                        (p_reg >= 4'(gi)) && (char_idx < len_reg);
      assign hex_next[gi] = char_vis ? ~msg_reg[{char_idx[2:0], 3'b000} +: 8]
                                     : HEX_OFF;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      winner_reg <= 1'b0;
      last_reg   <= 1'b1;
      msg_reg    <= '0;
      len_reg    <= '0;
      p_reg      <= '0;
      gnt_reg    <= 2'b00;
      done_reg   <= 2'b00;
      hex_reg    <= {N_DIGITS{HEX_OFF}};
    end else begin
      winner_reg <= winner_next;
      last_reg   <= last_next;
      msg_reg    <= msg_next;
      len_reg    <= len_next;
      p_reg      <= p_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      hex_reg    <= hex_next;
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE);
  assign HEX0 = hex_reg[0];
  assign HEX1 = hex_reg[1];
  assign HEX2 = hex_reg[2];
  assign HEX3 = hex_reg[3];

endmodule

// File: tb/tb_hex_msg_sched.sv
// -----------------------------------------------------------------------------
// tb_hex_msg_sched
// Stimulus issues services and pushes the expected service (who, message,
// clamped length, abort point) into a queue. A monitor on the falling clock
// edge pops a record whenever a grant appears and compares the grant, every
// scroll frame, the done pulse and post-abort/reset outputs against values
// derived from the display rules.
// -----------------------------------------------------------------------------
module tb_hex_msg_sched;
  import hex_sched_pkg::*;

  localparam int TD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N    = 1'b0;
  logic [1:0]  req      = 2'b00;
  logic [63:0] msg0     = '0;
  logic [63:0] msg1     = '0;
  logic [3:0]  len0     = '0;
  logic [3:0]  len1     = '0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        busy;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_msg_sched #(
    .TICK_DIV (TD),
    .N_DIGITS (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .req      (req),
    .msg0     (msg0),
    .msg1     (msg1),
    .len0     (len0),
    .len1     (len1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3)
  );

  typedef struct {
    int          who;
    logic [63:0] msg;
    int          len;
    int          cut_k;   // cycle after grant where an abort should land, -1 none
  } svc_t;

  svc_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   last_who   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame for scroll position p: digit d shows char p-d when it exists.
  function automatic logic [31:0] exp_frame(input logic [63:0] m, input int len, input int p);
    logic [31:0] f;
    for (int d = 0; d < 4; d++) begin
      int c;
      c = p - d;
      if (c >= 0 && c < len) f[8*d +: 8] = ~m[8*c +: 8];
      else                   f[8*d +: 8] = 8'hFF;
    end
    return f;
  endfunction

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  // Reference arbitration: lone requester wins, contention alternates.
  function automatic void push_svc(input logic [1:0] r, input int cut_k);
    svc_t s;
    int   w;
    if (r == 2'b01)      w = 0;
    else if (r == 2'b10) w = 1;
    else                 w = (last_who == 1) ? 0 : 1;
    last_who = w;
    s.who   = w;
    s.msg   = (w == 1) ? msg1 : msg0;
    s.len   = int'((w == 1) ? len1 : len0);
    if (s.len > 8) s.len = 8;
    s.cut_k = cut_k;
    exp_q.push_back(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  svc_t cur;
  bit   active = 1'b0;
  int   k      = 0;
  int   done_k = 0;

  always @(negedge CLOCK_50) begin
    if (!RST_N) begin
      chk("reset_gnt",  {30'd0, gnt},  32'd0);
      chk("reset_done", {30'd0, done}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hex",  {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
      active = 1'b0;
    end else if (!active) begin
      if (done != 2'b00) chk("spurious_done", {30'd0, done}, 32'd0);
      if (gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", {30'd0, gnt}, 32'd0);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          k      = 0;
          done_k = (cur.len == 0) ? 1 : (cur.len + 4) * TD + 1;
          chk("gnt", {30'd0, gnt}, {30'd0, onehot(cur.who)});
          chk("grant_busy", {31'd0, busy}, 32'd1);
          chk("grant_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
          $display("service: requester %0d len %0d", cur.who, cur.len);
        end
      end
    end else begin
      k++;
      if (cur.cut_k >= 0 && k == cur.cut_k) begin
        chk("abort_gnt",  {30'd0, gnt},  32'd0);
        chk("abort_done", {30'd0, done}, 32'd0);
        chk("abort_hex",  {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
        active = 1'b0;
      end else if (k == done_k) begin
        chk("done", {30'd0, done}, {30'd0, onehot(cur.who)});
        chk("done_gnt_clear", {30'd0, gnt}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
        active = 1'b0;
      end else begin
        if (done != 2'b00) chk("early_done", {30'd0, done}, 32'd0);
        if (cur.len > 0 && ((k - 1) % TD) == 0) begin
          chk($sformatf("frame_p%0d", (k - 1) / TD), {HEX3, HEX2, HEX1, HEX0},
              exp_frame(cur.msg, cur.len, (k - 1) / TD));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all waits bounded)
  // ---------------------------------------------------------------------------
  task automatic wait_gnt();
    int cyc;
    cyc = 0;
    do begin
      @(negedge CLOCK_50);
      cyc++;
    end while (gnt == 2'b00 && cyc < 100);
    if (gnt == 2'b00) chk("wait_gnt_timeout", {30'd0, gnt}, 32'd1);
  endtask

  task automatic wait_dones(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 200 * n) begin
      @(negedge CLOCK_50);
      cyc++;
      if (done != 2'b00) seen++;
    end
    if (seen < n) chk("wait_done_timeout", seen, n);
  endtask

  task automatic serve(input logic [1:0] r, input bit scramble);
    push_svc(r, -1);
    req = r;
    wait_gnt();
    if (scramble) begin
      msg0 = {$urandom, $urandom};
      msg1 = {$urandom, $urandom};
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
    end
    wait_dones(1);
    req = 2'b00;
  endtask

  initial begin
    msg0 = {$urandom, $urandom};
    msg1 = {$urandom, $urandom};
    repeat (3) @(negedge CLOCK_50);
    RST_N = 1'b1;
    last_who = 1;
    @(negedge CLOCK_50);

    // Contention straight out of reset: 0, 1, 0 while req=11 is held.
    len0 = 4'd3;
    len1 = 4'd2;
    push_svc(2'b11, -1);
    push_svc(2'b11, -1);
    push_svc(2'b11, -1);
    req = 2'b11;
    wait_dones(3);
    req = 2'b00;
    repeat (2) @(negedge CLOCK_50);

    // HELLO on requester 0.
    msg0 = {24'h0, SEG_O, SEG_L, SEG_L, SEG_E, SEG_H};
    len0 = 4'd5;
    serve(2'b01, 1'b0);
    @(negedge CLOCK_50);

    // Zero length, then over-long length clamped to 8.
    len0 = 4'd0;
    serve(2'b01, 1'b0);
    @(negedge CLOCK_50);
    msg0 = {$urandom, $urandom};
    len0 = 4'd12;
    serve(2'b01, 1'b1);
    @(negedge CLOCK_50);

    // Randomized services with inputs scrambled after grant.
    for (int i = 0; i < 20; i++) begin
      msg0 = {$urandom, $urandom};
      msg1 = {$urandom, $urandom};
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
      serve(2'($urandom_range(1, 3)), 1'b1);
      repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
    end

    // Requester 0 drops its request at p=2 while requester 1 waits.
    msg0 = {$urandom, $urandom};
    msg1 = {$urandom, $urandom};
    len0 = 4'd5;
    len1 = 4'd3;
`ifdef HEX_SCHED_ABORT_EN
    push_svc(2'b01, 2 * TD + 2);
`else
    push_svc(2'b01, -1);
`endif
    push_svc(2'b10, -1);
    req = 2'b01;
    wait_gnt();
    req = 2'b11;
    repeat (2 * TD + 1) @(negedge CLOCK_50);
    req = 2'b10;
`ifdef HEX_SCHED_ABORT_EN
    wait_dones(1);
`else
    wait_dones(2);
`endif
    req = 2'b00;
    repeat (2) @(negedge CLOCK_50);

    // Asynchronous reset at p=3: outputs clear at once, no done, last -> 1.
    msg0 = {$urandom, $urandom};
    len0 = 4'd6;
    push_svc(2'b01, -1);
    req = 2'b01;
    wait_gnt();
    repeat (3 * TD + 1) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #1 RST_N = 1'b0;
    last_who = 1;
    req = 2'b00;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    #1 RST_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Pointer back at 1, so contention goes to requester 0 first.
    msg0 = {$urandom, $urandom};
    msg1 = {$urandom, $urandom};
    len0 = 4'd2;
    len1 = 4'd4;
    serve(2'b11, 1'b0);

    repeat (10) @(negedge CLOCK_50);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_msg_sched.md
# hex_msg_sched

Display scheduler for the 7-segment HEX bank on CLOCK_50. Two requesters share it. Each requester provides a message of up to 8 segment-coded characters. Round-robin arbitration grants the display to one requester, which then scrolls its message leftward across N_DIGITS digits at a divided tick rate and receives a one-cycle done pulse at the end.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per scroll step; legal range ≥2.
- N_DIGITS, 4: number of HEX digits driven, fixed at 4 for port list.
- CLOCK_50  in  1  system clock.
- RST_N  in  1  reset; one clock; asynchronous assert, active-low.
- req  in  2  per-requester request level; bit i = requester i.
- msg0, msg1  in  64  messages; char k = msgN[8k+:8], active-high segments, bit7 = dp; char 0 is shown first.
- len0, len1  in  4  message length in characters; values >8 clamp to 8.
- gnt  out  2  one-hot grant; held from GRANT through DONE.
- done  out  2  one-cycle pulse to the served requester.
- busy  out  1  high in any state other than IDLE.
- HEX0..HEX3  out  8 each  active-low segments; HEX0 is rightmost; 8'hFF = blank.

## Operation
- States: IDLE → GRANT → SHOW → DONE → IDLE.
- IDLE: all HEX = 8'hFF. When any req bit is high, go to GRANT.
- Arbitration: pointer `last` (reset 1).
  - A single requester wins outright.
  - If both request, the requester ≠ `last` wins.
  - `last` is updated on leaving DONE or on abort.
- GRANT, one cycle: latch msg/len of the winner, clamp len, set gnt. If the latched len = 0, go directly to DONE with no display.
- SHOW: position p starts at 0.
  - Digit d shows ~char[p−d] when 0 ≤ p−d < len; otherwise it is blank.
  - Each tick increments p.
  - A tick at p = len+N_DIGITS−1 goes to DONE. At that point all digits are already blank.
  - Visible window: len+N_DIGITS ticks.
- DONE, one cycle: assert done[winner], then clear gnt the next cycle and return to IDLE.
- Latched message is stable during SHOW. msg/len inputs are ignored after GRANT.
- A new req during SHOW waits; it is granted in the next IDLE → GRANT cycle.

## Timing
- Reset values: state IDLE; gnt 0; done 0; busy 0; HEX0..HEX3 8'hFF; p 0; tick counter 0.
- HEX outputs are registered and update the cycle after the state/p change.
- Tick counter:
  - Cleared on entry to SHOW.
  - Tick fires when the counter reaches TICK_DIV−1, then the counter wraps to 0.
  - The first step therefore occurs exactly TICK_DIV cycles after SHOW entry.
- req high in IDLE → gnt high 2 cycles later (IDLE→GRANT, registered gnt).
- RST_N low mid-SHOW: immediate blank, gnt/done cleared, no done pulse, `last` back to 1.
- Simultaneous tick and abort: abort wins.

## Configuration
- HEX_SCHED_ABORT_EN defined: the granted requester dropping its req during SHOW aborts.
  - Next cycle: IDLE, blank, gnt cleared, no done pulse, `last` = aborted requester.
- Not defined: req is ignored after GRANT, and the scroll always runs to DONE.

## Structure
- Package hex_sched_pkg holds:
  - The state enum (IDLE, GRANT, SHOW, DONE).
  - SEG_BLANK = 8'h00 (active-high).
  - Letter constants SEG_H 8'h76, SEG_E 8'h79, SEG_L 8'h38, SEG_O 8'h3F for test messages.
- One sub-module, hex_tick_gen, parameterized by TICK_DIV:
  - Inputs: clear and enable.
  - Output: a one-cycle tick pulse.

## Test plan
- Single scroll: TICK_DIV=4, req=01, msg0="HELLO" (76,79,38,38,3F), len0=5.
  - At p=0: HEX0=~76, HEX1..3=FF.
  - At p=4: HEX3..HEX0 = ~79,~38,~38,~3F.
  - done[0] pulses once after 9 ticks.
- Contention: req=11 from reset.
  - Requester 0 is served first, then requester 1.
  - req=11 held again afterwards → requester 0 is served next; grants alternate.
- len0=0: GRANT → DONE; done[0] pulses 2 cycles after GRANT, with HEX never non-blank. len0=12 behaves identically to len0=8.
- Async reset: RST_N low at p=3 → all outputs return to reset values within the same cycle; no done pulse.
- Abort, HEX_SCHED_ABORT_EN defined: drop req[0] at p=2 → IDLE next cycle, no done, pending req[1] granted.
- Abort, HEX_SCHED_ABORT_EN not defined: the same stimulus completes the full scroll and produces the done pulse.
